// File: rtl/digit_serial_multiplier.sv
// Digit-serial WIDTH x WIDTH unsigned multiplier built on a 2x2 combinational core.
// Optional build macro DSM_ZERO_SKIP_EN: complete in one cycle when either operand is zero.

module two_bit_multiplier (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic [3:0] p
);
    assign p = {2'b00, x} * {2'b00, y};
endmodule

module digit_serial_multiplier #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int unsigned N  = WIDTH / 2;
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SW = $clog2(PW) + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_n;
    logic [WIDTH-1:0]  ra, ra_n, rb, rb_n;
    logic [PW-1:0]     acc, acc_n, product_n;
    logic [IW-1:0]     i_idx, i_n, j_idx, j_n;
    logic              busy_n, done_n;

    logic [1:0]        da, db;
    logic [3:0]        pp;
    logic [SW-1:0]     sh;
    logic [PW-1:0]     sum;
    logic              last;

    // Digit selection and shifted accumulation of the current partial product
    assign da   = 2'(ra >> {i_idx, 1'b0});
    assign db   = 2'(rb >> {j_idx, 1'b0});
    assign sh   = (SW'(i_idx) + SW'(j_idx)) << 1;
    assign sum  = acc + (PW'(pp) << sh);
    assign last = (i_idx == IW'(N - 1)) && (j_idx == IW'(N - 1));

    two_bit_multiplier u_core (
        .x (da),
        .y (db),
        .p (pp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ra      <= '0;
            rb      <= '0;
            acc     <= '0;
            i_idx   <= '0;
            j_idx   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            state   <= state_n;
            ra      <= ra_n;
            rb      <= rb_n;
            acc     <= acc_n;
            i_idx   <= i_n;
            j_idx   <= j_n;
            busy    <= busy_n;
            done    <= done_n;
            product <= product_n;
        end
    end

    always_comb begin
        state_n   = state;
        ra_n      = ra;
        rb_n      = rb;
        acc_n     = acc;
        i_n       = i_idx;
        j_n       = j_idx;
        busy_n    = busy;
        done_n    = 1'b0;
        product_n = product;

        case (state)
            IDLE: begin
                if (start) begin
                    ra_n    = a;
                    rb_n    = b;
                    acc_n   = '0;
                    i_n     = '0;
                    j_n     = '0;
                    busy_n  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
`ifdef DSM_ZERO_SKIP_EN
                if ((ra == '0) || (rb == '0)) begin
                    product_n = '0;
                    done_n    = 1'b1;
                    busy_n    = 1'b0;
                    i_n       = '0;
                    j_n       = '0;
                    state_n   = IDLE;
                end else
`endif
                begin
                    acc_n = sum;
                    if (last) begin
                        // Capture the final sum directly; acc itself lags by one partial product
                        product_n = sum;
                        done_n    = 1'b1;
                        busy_n    = 1'b0;
                        i_n       = '0;
                        j_n       = '0;
                        state_n   = IDLE;
                    end else if (j_idx == IW'(N - 1)) begin
                        j_n = '0;
                        i_n = i_idx + IW'(1);
                    end else begin
                        j_n = j_idx + IW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: doc/digit_serial_multiplier.md
# digit_serial_multiplier

Sequential WIDTH×WIDTH unsigned multiplier built around the existing 2×2 combinational multiplier core. The block feeds 2-bit digit pairs of latched operands into one `two_bit_multiplier` instance and consumes its 4-bit partial products. Each partial product is shifted and accumulated into a 2·WIDTH-bit sum, one digit pair per clock. It sits between an operand source using a start/busy/done handshake and any consumer of the full product.

## Interface
- `WIDTH`, default 8: operand width in bits. Must be even and ≥ 2. N = WIDTH/2 digits per operand.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a multiply. Sampled only in IDLE.
- `a` input WIDTH: multiplicand. Captured on the accepting edge.
- `b` input WIDTH: multiplier. Captured on the accepting edge.
- `busy` output 1: high while an operation is in progress.
- `done` output 1: one-cycle pulse, high for the cycle after the result is written.
- `product` output 2·WIDTH: result register. Holds the last completed result until the next completion.

## Operation
- States: IDLE, RUN.
- IDLE, start=1:
  - latch a→ra and b→rb
  - clear acc
  - set digit indices i=0, j=0
  - set busy=1
  - go to RUN
- IDLE, start=0: hold all state.
- RUN, every cycle:
  - drive the core with ra[2i+1:2i] and rb[2j+1:2j]
  - acc ← acc + (pp << 2·(i+j)), where pp is the 4-bit core output, zero-extended to 2·WIDTH
  - j increments each cycle; on j=N−1, j wraps to 0 and i increments
- Last RUN cycle (i=N−1, j=N−1):
  - product ← final sum (acc + shifted pp), not the stale acc
  - done=1, busy=0
  - go to IDLE
- Arithmetic is unsigned. The accumulator cannot overflow 2·WIDTH bits; no saturation or wrap handling is needed.
- start while busy: ignored. Operands a/b changing during RUN have no effect.
- start in the cycle done is high: accepted, because the FSM is already in IDLE. This gives back-to-back operations with no dead cycle.
- Reset, including mid-operation:
  - state=IDLE, busy=0, done=0, product=0, acc=0, i=j=0
  - any in-flight operation is discarded; no done is produced for it.

## Timing
- Edge 0: start accepted. busy=1 after edge 0.
- Edges 1..N²: one accumulation each (N²=16 for WIDTH=8).
- Edge N²: product updated, done=1, busy=0. done is visible for exactly the one cycle after edge N².
- Start-to-done latency: N² cycles (16 for WIDTH=8; 1 for WIDTH=2).
- Throughput: one result per N² cycles with back-to-back starts.
- done and busy are never high in the same cycle.
- product changes only on a completing edge or on reset.

## Configuration
- Macro: `DSM_ZERO_SKIP_EN`.
- Defined: if ra==0 or rb==0 at acceptance, the block skips RUN.
  - At edge 1: product ← 0, done=1, busy=0.
  - Latency is 1 cycle. busy is high only between edges 0 and 1.
- Not defined: zero operands take the full N² cycles like any other operands, and produce product=0.
- Non-zero operands behave identically in both builds.

## Test plan
- WIDTH=8, a=8'hFF, b=8'hFF, start pulse → busy for 16 cycles; done after edge 16; product=16'hFE01.
- a=8'd3, b=8'd3 → product=16'd9. Then, in the done cycle, start with a=8'd200, b=8'd100 → accepted immediately; product=16'd20000 after 16 more edges.
- a=8'd0, b=8'hA5:
  - without DSM_ZERO_SKIP_EN → done at edge 16, product=0
  - with DSM_ZERO_SKIP_EN → done at edge 1, product=0
- Start a=8'd12, b=8'd34. Pulse start with a=8'hFF, b=8'hFF at edge 5 → ignored; product=16'd408 at edge 16.
- Start a=8'hF0, b=8'h0F. Assert rst at edge 7 → next cycle busy=0, done=0, product=0; no done pulse follows. A fresh start with a=8'd7, b=8'd6 → product=16'd42.
- Exhaustive WIDTH=4 sweep of all 256 operand pairs → product = a·b for each, with done exactly 4 cycles after acceptance.
